// File: rtl/btn_led_pkg.sv
// Shared definitions for the push-button to LED controller: mode encodings
// and the helper that sizes the debounce and pulse counters.
package btn_led_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_TOGGLE = 2'b00;
    localparam logic [MODE_W-1:0] MODE_MOMENT = 2'b01;
    localparam logic [MODE_W-1:0] MODE_TIMED  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_OFF    = 2'b11;

    // Bits needed to hold the values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, counter debouncer and press-edge
// detector. db_out is the accepted (debounced) level; rise_out is high while
// the accepted level has just gone high and the delayed copy has not yet.
module btn_debounce
    import btn_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1200000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic btn_in,
    output logic db_out,
    output logic rise_out
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_db_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    // Bring the asynchronous button into the sysclk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two synchronizer stages into one.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= btn_in;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it has differed from the accepted one for
    // DEBOUNCE_CYCLES consecutive cycles; any glitch back restarts the count.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else if (r_s2 == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_db  <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Delayed copy of the accepted level for edge detection.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_db_q <= 1'b0;
        end else begin
            r_db_q <= r_db;
        end
    end

    assign w_rise   = r_db & ~r_db_q;
    assign db_out   = r_db;
    assign rise_out = w_rise;

endmodule

// File: rtl/btn_led_ctrl.sv
// Multi-channel push-button to LED controller. Each channel debounces its
// button and drives its LED in toggle, momentary, timed-pulse or off mode.
// A mode change clears that channel's toggle state and pulse timer; a press
// landing on the same cycle is applied under the new mode.
module btn_led_ctrl
    import btn_led_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 1200000,
    parameter int PULSE_CYCLES    = 6000000
) (
    input  logic                     sysclk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          btn,
    input  logic [MODE_W*N_CH-1:0]   mode,
    output logic [N_CH-1:0]          led,
    output logic [N_CH-1:0]          press
);

    localparam int               TMR_W    = cnt_width(PULSE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PULSE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic              w_db;
        logic              w_rise;
        logic [MODE_W-1:0] w_mode;
        logic              w_mode_chg;
        logic              w_tstate_base;
        logic [TMR_W-1:0]  w_timer_base;
        logic              w_tstate_nxt;
        logic [TMR_W-1:0]  w_timer_nxt;
        logic              w_led_nxt;

        logic [MODE_W-1:0] r_mode_q;
        logic              r_tstate;
        logic [TMR_W-1:0]  r_timer;
        logic              r_led;
        logic              r_press;

        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .sysclk   (sysclk),
            .rst      (rst),
            .btn_in   (btn[g]),
            .db_out   (w_db),
            .rise_out (w_rise)
        );

        assign w_mode     = mode[MODE_W*g +: MODE_W];
        assign w_mode_chg = (w_mode != r_mode_q);

        // Next toggle state, timer and LED level for this channel's mode.
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        always_comb begin
            w_tstate_base = w_mode_chg ? 1'b0 : r_tstate;
            w_timer_base  = w_mode_chg ? '0   : r_timer;
            w_tstate_nxt  = w_tstate_base;
            w_timer_nxt   = w_timer_base;
            w_led_nxt     = 1'b0;
            case (w_mode)
                MODE_TOGGLE: begin
                    if (w_rise) begin
                        w_tstate_nxt = ~w_tstate_base;
                    end
                    w_led_nxt = w_tstate_nxt;
                end
                MODE_MOMENT: begin
                    w_led_nxt = w_db;
                end
                MODE_TIMED: begin
                    if (w_rise) begin
                        w_timer_nxt = TMR_LOAD;
                        w_led_nxt   = 1'b1;
                    end else if (w_timer_base != '0) begin
                        w_timer_nxt = w_timer_base - TMR_ONE;
                        w_led_nxt   = (w_timer_base > TMR_ONE);
                    end
                end
                default: begin
                    w_led_nxt = 1'b0;
                end
            endcase
        end

        // Register mode history, mode-engine state and both outputs.
        always_ff @(posedge sysclk) begin
            if (rst) begin
                r_mode_q <= MODE_TOGGLE;
                r_tstate <= 1'b0;
                r_timer  <= '0;
                r_led    <= 1'b0;
                r_press  <= 1'b0;
            end else begin
                r_mode_q <= w_mode;
                r_tstate <= w_tstate_nxt;
                r_timer  <= w_timer_nxt;
                r_led    <= w_led_nxt;
                r_press  <= w_rise;
            end
        end

        assign led[g]   = r_led;
        assign press[g] = r_press;

    end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Self-checking bench for btn_led_ctrl with short debounce/pulse lengths.
// A cycle-level reference model derived from the behavioural rules predicts
// led and press; directed scenarios add explicit timing expectations.
module tb_btn_led_ctrl;

    localparam int N_CH = 2;
    localparam int D    = 4;
    localparam int P    = 10;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   btn;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   led;
    logic [N_CH-1:0]   press;

    int n_checks;
    int n_errors;

    // Reference model state, one entry per channel.
    int        m_s1 [N_CH];
    int        m_s2 [N_CH];
    int        m_db [N_CH];
    int        m_dbq[N_CH];
    int        m_run[N_CH];
    int        m_tog[N_CH];
    int        m_rem[N_CH];
    int        m_mprev[N_CH];
    logic [N_CH-1:0] m_led;
    logic [N_CH-1:0] m_press;

    btn_led_ctrl #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P)
    ) dut (
        .sysclk (clk),
        .rst    (rst),
        .btn    (btn),
        .mode   (mode),
        .led    (led),
        .press  (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_db[c] = 0; m_dbq[c] = 0;
                m_run[c] = 0; m_tog[c] = 0; m_rem[c] = 0; m_mprev[c] = 0;
                m_led[c] = 1'b0; m_press[c] = 1'b0;
            end else begin
                int md;
                int pressed;
                md      = int'(mode[2*c +: 2]);
                pressed = (m_db[c] == 1 && m_dbq[c] == 0) ? 1 : 0;
                if (md != m_mprev[c]) begin
                    m_tog[c] = 0;
                    m_rem[c] = 0;
                end
                m_press[c] = (pressed == 1);
                case (md)
                    0: begin
                        if (pressed == 1) m_tog[c] = 1 - m_tog[c];
                        m_led[c] = (m_tog[c] == 1);
                    end
                    1: m_led[c] = (m_db[c] == 1);
                    2: begin
                        if (pressed == 1)       m_rem[c] = P;
                        else if (m_rem[c] > 0)  m_rem[c] = m_rem[c] - 1;
                        m_led[c] = (m_rem[c] > 0);
                    end
                    default: m_led[c] = 1'b0;
                endcase
                m_mprev[c] = md;
                m_dbq[c]   = m_db[c];
                if (m_s2[c] != m_db[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_db[c]  = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = btn[c] ? 1 : 0;
            end
        end
    endtask

    // One clock edge: update the model at the edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        btn  = 2'b11;
        mode = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (led !== 2'b00 || press !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d led=%b press=%b want 00/00", i, led, press);
            end
        end
        rst = 1'b0;
        btn = 2'b00;
        step();
        n_checks++;
        if (led !== 2'b00 || press !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_release led=%b press=%b want 00/00", led, press);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL reset_idle led=%b/%b press=%b/%b", led, m_led, press, m_press);
            end
        end
    endtask

    task automatic test_toggle();
        mode = 4'b0000;
        for (int rep = 0; rep < 2; rep++) begin
            btn[0] = 1'b1;
            for (int t = 1; t <= 20; t++) begin
                logic exp_led;
                step();
                exp_led = (t >= 7) ? (rep == 0) : (rep == 1);
                n_checks++;
                if (press[0] !== (t == 7) || led[0] !== exp_led ||
                    led !== m_led || press !== m_press) begin
                    n_errors++;
                    $display("FAIL toggle_press rep=%0d t=%0d led=%b press=%b want led0=%b press0=%b model %b/%b",
                             rep, t, led, press, exp_led, (t == 7), m_led, m_press);
                end
            end
            btn[0] = 1'b0;
            for (int t = 1; t <= 20; t++) begin
                step();
                n_checks++;
                if (press[0] !== 1'b0 || led[0] !== (rep == 0) ||
                    led !== m_led || press !== m_press) begin
                    n_errors++;
                    $display("FAIL toggle_release rep=%0d t=%0d led=%b press=%b want led0=%b press0=0",
                             rep, t, led, press, (rep == 0));
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        int         presses;
        pat     = 10'b1111101101; // applied LSB first: 1,0,1,1,0,1,1,1,1,1
        presses = 0;
        for (int t = 0; t < 40; t++) begin
            btn[0] = (t < 10) ? pat[t] : (t < 20);
            step();
            if (press[0] === 1'b1) presses++;
            n_checks++;
            if (led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL bounce_model t=%0d led=%b/%b press=%b/%b", t, led, m_led, press, m_press);
            end
        end
        n_checks++;
        if (presses != 1) begin
            n_errors++;
            $display("FAIL bounce_count presses=%0d want 1", presses);
        end
    endtask

    task automatic test_timed();
        int high_cnt;
        mode = 4'b1000;
        btn  = 2'b00;
        step();
        // Single press: LED on for exactly P cycles.
        high_cnt = 0;
        for (int t = 1; t <= 30; t++) begin
            btn[1] = (t <= 12);
            step();
            if (led[1] === 1'b1) high_cnt++;
            n_checks++;
            if (led[1] !== (t >= 7 && t <= 6 + P) || led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL timed_single t=%0d led=%b press=%b model %b/%b", t, led, press, m_led, press);
            end
        end
        n_checks++;
        if (high_cnt != P) begin
            n_errors++;
            $display("FAIL timed_single_len got=%0d want %0d", high_cnt, P);
        end
        // Retrigger: second response 8 cycles into the pulse reloads the timer.
        high_cnt = 0;
        for (int t = 1; t <= 45; t++) begin
            btn[1] = (t <= 4) || (t >= 9 && t <= 20);
            step();
            if (led[1] === 1'b1) high_cnt++;
            n_checks++;
            if (press[1] !== (t == 7 || t == 15) || led[1] !== (t >= 7 && t <= 14 + P) ||
                led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL timed_retrigger t=%0d led=%b press=%b model %b/%b", t, led, press, m_led, m_press);
            end
        end
        n_checks++;
        if (high_cnt != 8 + P) begin
            n_errors++;
            $display("FAIL timed_retrigger_len got=%0d want %0d", high_cnt, 8 + P);
        end
    endtask

    task automatic test_momentary_indep();
        mode = 4'b0001;
        for (int t = 1; t <= 30; t++) begin
            btn = (t <= 10) ? 2'b11 : 2'b00;
            step();
            n_checks++;
            if (press !== ((t == 7) ? 2'b11 : 2'b00) || led[0] !== (t >= 7 && t <= 16) ||
                led[1] !== (t >= 7) || led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL momentary_indep t=%0d led=%b press=%b model %b/%b", t, led, press, m_led, m_press);
            end
        end
    endtask

    task automatic test_mode_change_reset();
        mode = 4'b0000;
        for (int t = 1; t <= 20; t++) begin
            btn[0] = (t <= 8);
            step();
        end
        n_checks++;
        if (led[0] !== 1'b1 || led !== m_led) begin
            n_errors++;
            $display("FAIL mode_toggle_on led=%b want led0=1 model %b", led, m_led);
        end
        mode[1:0] = 2'b11;
        for (int t = 0; t < 3; t++) begin
            step();
            n_checks++;
            if (led[0] !== 1'b0 || led !== m_led) begin
                n_errors++;
                $display("FAIL mode_off t=%0d led=%b want led0=0", t, led);
            end
        end
        mode[1:0] = 2'b00;
        for (int t = 0; t < 3; t++) begin
            step();
            n_checks++;
            if (led[0] !== 1'b0 || led !== m_led) begin
                n_errors++;
                $display("FAIL mode_back_tstate_clear t=%0d led=%b want led0=0", t, led);
            end
        end
        for (int t = 1; t <= 20; t++) begin
            btn[0] = (t <= 8);
            step();
        end
        n_checks++;
        if (led[0] !== 1'b1 || led !== m_led) begin
            n_errors++;
            $display("FAIL mode_repress led=%b want led0=1", led);
        end
        // Reset in the middle of a timed pulse.
        mode = 4'b1000;
        for (int t = 1; t <= 9; t++) begin
            btn[1] = 1'b1;
            step();
        end
        n_checks++;
        if (led[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL timed_before_rst led=%b want led1=1", led);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (led !== 2'b00 || press !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_mid_pulse led=%b press=%b want 00/00", led, press);
        end
        rst = 1'b0;
        btn = 2'b00;
        for (int t = 0; t < 10; t++) begin
            step();
            n_checks++;
            if (led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL post_rst t=%0d led=%b/%b press=%b/%b", t, led, m_led, press, m_press);
            end
        end
    endtask

    task automatic test_random();
        int hold[N_CH];
        for (int c = 0; c < N_CH; c++) hold[c] = 0;
        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    btn[c]  = ~btn[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 14));
                end else begin
                    hold[c] = hold[c] - 1;
                end
                if ($urandom_range(0, 49) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 249) == 0);
            step();
            n_checks++;
            if (led !== m_led || press !== m_press) begin
                n_errors++;
                $display("FAIL random t=%0d led=%b/%b press=%b/%b mode=%b", t, led, m_led, press, m_press, mode);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        btn  = '0;
        mode = '0;
        test_reset();
        test_toggle();
        test_bounce();
        test_timed();
        test_momentary_indep();
        test_mode_change_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
